// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: NOP encoding, queue entry layout, pointer sizing.
// MISALIGN_CHECK_EN adds a per-entry misaligned flag.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam int          DEFAULT_XLEN = 32;

    // Entry layout at the default PC width; the queue declares the same shape at its own XLEN.
    typedef struct packed {
        logic [31:0]             instr;
        logic [DEFAULT_XLEN-1:0] pc;
`ifdef MISALIGN_CHECK_EN
        logic                    misaligned;
`endif
    } fetch_entry_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x WIDTH register array, one synchronous write port and one asynchronous read port.
// Contents are intentionally not reset.
module fetch_queue_mem #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Registered FIFO between the imem response channel and decode; flush empties it.
// Build option MISALIGN_CHECK_EN adds instr_misaligned_out and a per-entry misaligned bit.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     flush_in,
    input  logic                     imem_valid_in,
    input  logic [31:0]              imem_instr_in,
    input  logic [XLEN-1:0]          imem_pc_in,
    output logic                     imem_ready_out,
    input  logic                     dec_ready_in,
    output logic [31:0]              instr_out,
    output logic [XLEN-1:0]          pc_out,
    output logic                     instr_valid_out,
    output logic                     bubble_out,
`ifdef MISALIGN_CHECK_EN
    output logic                     instr_misaligned_out,
`endif
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
`ifdef MISALIGN_CHECK_EN
        logic            misaligned;
`endif
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               push;
    logic               pop;
    entry_t             wr_entry;
    entry_t             head;
    logic [ENTRY_W-1:0] rd_data;

    // Handshakes: a transfer happens only on a cycle where valid and ready are both high
    // and no flush is pending; ready never depends on the consumer's ready.
    assign imem_ready_out  = (count != CNT_W'(DEPTH));
    assign instr_valid_out = (count != '0);
    assign push            = imem_valid_in & imem_ready_out & ~flush_in;
    assign pop             = instr_valid_out & dec_ready_in & ~flush_in;
    assign bubble_out      = ~instr_valid_out | flush_in;
    assign count_out       = count;

    always_comb begin
        wr_entry       = '0;
        wr_entry.instr = imem_instr_in;
        wr_entry.pc    = imem_pc_in;
`ifdef MISALIGN_CHECK_EN
        wr_entry.misaligned = |imem_pc_in[1:0];
`endif
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk_in),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign head = entry_t'(rd_data);

    // The head slot may hold stale or never-written data while empty, so gate every field.
    always_comb begin
        instr_out = NOP_INSTR;
        pc_out    = '0;
        if (instr_valid_out) begin
            instr_out = head.instr;
            pc_out    = head.pc;
`ifdef MISALIGN_CHECK_EN
            if (head.misaligned) begin
                instr_out = NOP_INSTR;
            end
`endif
        end
    end

`ifdef MISALIGN_CHECK_EN
    assign instr_misaligned_out = instr_valid_out & head.misaligned;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus randomized traffic
// against a queue-based reference model. Define MISALIGN_CHECK_EN to cover that option.
module tb_instr_fetch_queue;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              flush_in;
    logic              imem_valid_in;
    logic [31:0]       imem_instr_in;
    logic [XLEN-1:0]   imem_pc_in;
    logic              imem_ready_out;
    logic              dec_ready_in;
    logic [31:0]       instr_out;
    logic [XLEN-1:0]   pc_out;
    logic              instr_valid_out;
    logic              bubble_out;
    logic [$clog2(DEPTH):0] count_out;
`ifdef MISALIGN_CHECK_EN
    logic              instr_misaligned_out;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: entries stored as {instr, pc}, oldest at index 0.
    logic [32+XLEN-1:0] exp_q[$];

    instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .flush_in        (flush_in),
        .imem_valid_in   (imem_valid_in),
        .imem_instr_in   (imem_instr_in),
        .imem_pc_in      (imem_pc_in),
        .imem_ready_out  (imem_ready_out),
        .dec_ready_in    (dec_ready_in),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .instr_valid_out (instr_valid_out),
        .bubble_out      (bubble_out),
`ifdef MISALIGN_CHECK_EN
        .instr_misaligned_out (instr_misaligned_out),
`endif
        .count_out       (count_out)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    // ---------------- model ----------------
    function automatic logic model_misaligned();
        logic [32+XLEN-1:0] e;
        if (exp_q.size() == 0) return 1'b0;
        e = exp_q[0];
`ifdef MISALIGN_CHECK_EN
        return |e[1:0];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_instr();
        logic [32+XLEN-1:0] e;
        if (exp_q.size() == 0) return NOP;
        if (model_misaligned()) return NOP;
        e = exp_q[0];
        return e[32+XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] model_pc();
        logic [32+XLEN-1:0] e;
        if (exp_q.size() == 0) return '0;
        e = exp_q[0];
        return e[XLEN-1:0];
    endfunction

    // ---------------- driver ----------------
    // Called ~1 time unit after a rising edge; advances one clock and updates the model.
    task automatic advance();
        logic m_push;
        logic m_pop;
        m_push = imem_valid_in && (exp_q.size() != DEPTH) && !flush_in;
        m_pop  = (exp_q.size() != 0) && dec_ready_in && !flush_in;
        @(posedge clk_in);
        if (rst_in || flush_in) begin
            exp_q.delete();
        end else begin
            if (m_pop)  void'(exp_q.pop_front());
            if (m_push) exp_q.push_back({imem_instr_in, imem_pc_in});
        end
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc, input logic rdy);
        imem_valid_in = v;
        imem_instr_in = ins;
        imem_pc_in    = pc;
        dec_ready_in  = rdy;
    endtask

    task automatic drain();
        offer(1'b0, 32'h0, '0, 1'b1);
        flush_in = 1'b0;
        repeat (DEPTH + 1) advance();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_in = 1'b1;
        flush_in = 1'b0;
        offer(1'b0, 32'h0, '0, 1'b0);
        advance();
        advance();
        rst_in = 1'b0;
        #1;
        n_cmp++; if (instr_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid_out); end
        n_cmp++; if (bubble_out !== 1'b1) begin n_fail++; $display("FAIL reset_bubble: got %b want 1", bubble_out); end
        n_cmp++; if (instr_out !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr_out, NOP); end
        n_cmp++; if (pc_out !== '0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc_out); end
        n_cmp++; if (imem_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", imem_ready_out); end
        n_cmp++; if (count_out !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_out); end
        advance();
    endtask

    task automatic test_single();
        offer(1'b1, 32'h00500093, 32'h100, 1'b1);
        advance();
        offer(1'b0, 32'h0, '0, 1'b1);
        #1;
        n_cmp++; if (instr_out !== 32'h00500093) begin n_fail++; $display("FAIL single_instr: got %h want 00500093", instr_out); end
        n_cmp++; if (pc_out !== 32'h100) begin n_fail++; $display("FAIL single_pc: got %h want 100", pc_out); end
        n_cmp++; if (instr_valid_out !== 1'b1 || bubble_out !== 1'b0) begin n_fail++; $display("FAIL single_valid: got v%b b%b want v1 b0", instr_valid_out, bubble_out); end
        advance();
        #1;
        n_cmp++; if (instr_valid_out !== 1'b0 || instr_out !== NOP || bubble_out !== 1'b1) begin n_fail++; $display("FAIL single_empty: got v%b i%h b%b want v0 i%h b1", instr_valid_out, instr_out, bubble_out, NOP); end
    endtask

    task automatic test_fill_stall();
        offer(1'b1, 32'h00100093, 32'h100, 1'b0);
        advance();
        offer(1'b1, 32'h00200093, 32'h104, 1'b0);
        advance();
        offer(1'b1, 32'h00300093, 32'h108, 1'b0);
        #1;
        n_cmp++; if (count_out !== 2 || imem_ready_out !== 1'b0) begin n_fail++; $display("FAIL stall_full: got c%0d r%b want c2 r0", count_out, imem_ready_out); end
        advance();
        #1;
        n_cmp++; if (count_out !== 2 || pc_out !== 32'h100) begin n_fail++; $display("FAIL stall_hold: got c%0d pc%h want c2 pc100", count_out, pc_out); end
        dec_ready_in = 1'b1;
        advance();
        #1;
        n_cmp++; if (pc_out !== 32'h104 || count_out !== 1) begin n_fail++; $display("FAIL stall_head2: got pc%h c%0d want pc104 c1", pc_out, count_out); end
        advance();
        imem_valid_in = 1'b0;
        #1;
        n_cmp++; if (pc_out !== 32'h108 || instr_out !== 32'h00300093) begin n_fail++; $display("FAIL stall_head3: got pc%h i%h want pc108 i00300093", pc_out, instr_out); end
        advance();
        #1;
        n_cmp++; if (instr_valid_out !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b want 0", instr_valid_out); end
    endtask

    task automatic test_full_push_pop();
        offer(1'b1, 32'h00a00093, 32'h300, 1'b0);
        advance();
        offer(1'b1, 32'h00b00093, 32'h304, 1'b0);
        advance();
        offer(1'b1, 32'h00c00093, 32'h308, 1'b1);
        #1;
        n_cmp++; if (imem_ready_out !== 1'b0) begin n_fail++; $display("FAIL fpp_ready_full: got %b want 0", imem_ready_out); end
        advance();
        #1;
        n_cmp++; if (count_out !== 1 || imem_ready_out !== 1'b1 || pc_out !== 32'h304) begin n_fail++; $display("FAIL fpp_after_pop: got c%0d r%b pc%h want c1 r1 pc304", count_out, imem_ready_out, pc_out); end
        advance();
        imem_valid_in = 1'b0;
        dec_ready_in  = 1'b0;
        #1;
        n_cmp++; if (count_out !== 1 || pc_out !== 32'h308) begin n_fail++; $display("FAIL fpp_push_pop: got c%0d pc%h want c1 pc308", count_out, pc_out); end
        drain();
    endtask

    task automatic test_flush();
        offer(1'b1, 32'h01000093, 32'h400, 1'b0);
        advance();
        offer(1'b1, 32'h01100093, 32'h404, 1'b0);
        advance();
        offer(1'b1, 32'h0dead093, 32'h1f0, 1'b1);
        flush_in = 1'b1;
        #1;
        n_cmp++; if (bubble_out !== 1'b1) begin n_fail++; $display("FAIL flush_bubble_now: got %b want 1", bubble_out); end
        advance();
        flush_in = 1'b0;
        offer(1'b1, 32'h02000093, 32'h200, 1'b0);
        #1;
        n_cmp++; if (count_out !== 0 || bubble_out !== 1'b1 || instr_valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got c%0d b%b v%b want c0 b1 v0", count_out, bubble_out, instr_valid_out); end
        advance();
        imem_valid_in = 1'b0;
        #1;
        n_cmp++; if (pc_out !== 32'h200 || instr_out !== 32'h02000093 || count_out !== 1) begin n_fail++; $display("FAIL flush_next_head: got pc%h i%h c%0d want pc200 i02000093 c1", pc_out, instr_out, count_out); end
        drain();
    endtask

`ifdef MISALIGN_CHECK_EN
    task automatic test_misalign();
        offer(1'b1, 32'h00500093, 32'h102, 1'b0);
        advance();
        imem_valid_in = 1'b0;
        #1;
        n_cmp++; if (instr_misaligned_out !== 1'b1 || instr_out !== NOP || pc_out !== 32'h102) begin n_fail++; $display("FAIL misalign_set: got m%b i%h pc%h want m1 i%h pc102", instr_misaligned_out, instr_out, pc_out, NOP); end
        dec_ready_in = 1'b1;
        advance();
        #1;
        n_cmp++; if (instr_misaligned_out !== 1'b0 || instr_valid_out !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got m%b v%b want m0 v0", instr_misaligned_out, instr_valid_out); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 400; i++) begin
            rst_in   = ($urandom_range(0, 99) == 0);
            flush_in = ($urandom_range(0, 15) == 0);
            r = $urandom;
`ifdef MISALIGN_CHECK_EN
            if ($urandom_range(0, 3) != 0) r = r & ~32'h3;
`else
            r = r & ~32'h3;
`endif
            offer($urandom_range(0, 2) != 0, $urandom, r, $urandom_range(0, 3) != 0);
            #1;
            n_cmp++; if (count_out !== exp_q.size()) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, count_out, exp_q.size()); end
            n_cmp++; if (imem_ready_out !== (exp_q.size() != DEPTH)) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", i, imem_ready_out, exp_q.size() != DEPTH); end
            n_cmp++; if (instr_valid_out !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", i, instr_valid_out, exp_q.size() != 0); end
            n_cmp++; if (instr_out !== model_instr()) begin n_fail++; $display("FAIL rand_instr[%0d]: got %h want %h", i, instr_out, model_instr()); end
            n_cmp++; if (pc_out !== model_pc()) begin n_fail++; $display("FAIL rand_pc[%0d]: got %h want %h", i, pc_out, model_pc()); end
            n_cmp++; if (bubble_out !== ((exp_q.size() == 0) || flush_in)) begin n_fail++; $display("FAIL rand_bubble[%0d]: got %b want %b", i, bubble_out, (exp_q.size() == 0) || flush_in); end
`ifdef MISALIGN_CHECK_EN
            n_cmp++; if (instr_misaligned_out !== model_misaligned()) begin n_fail++; $display("FAIL rand_misalign[%0d]: got %b want %b", i, instr_misaligned_out, model_misaligned()); end
`endif
            advance();
        end
        rst_in   = 1'b0;
        flush_in = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_in   = 1'b1;
        flush_in = 1'b0;
        offer(1'b0, 32'h0, '0, 1'b0);
        #1;
        test_reset();
        test_single();
        test_fill_stall();
        test_full_push_pop();
        test_flush();
`ifdef MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_random();
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
